// File: rtl/bcd_display_pkg.sv
// Shared types, segment codes and helpers for the BCD scan display.
// Holds the double-dabble step and the 0..99 clamp used by the converter and the top.
package bcd_display_pkg;

  localparam int unsigned VAL_W = 7;
  localparam int unsigned BCD_W = 8;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned IDX_W = 2;

  localparam logic [VAL_W-1:0] VAL_MAX = 7'd99;

  typedef enum logic [1:0] {IDLE, CONV_LO, CONV_HI, COMMIT} state_e;

  localparam logic [IDX_W-1:0] IDX_LO_ONES = 2'd0;
  localparam logic [IDX_W-1:0] IDX_LO_TENS = 2'd1;
  localparam logic [IDX_W-1:0] IDX_HI_ONES = 2'd2;
  localparam logic [IDX_W-1:0] IDX_HI_TENS = 2'd3;

  // Active-low segment codes, bit 6 = g ... bit 0 = a
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  function automatic logic [VAL_W-1:0] clamp99(input logic [VAL_W-1:0] v);
    return (v > VAL_MAX) ? VAL_MAX : v;
  endfunction

  // One double-dabble iteration: add 3 to any digit >= 5, then shift in the next bit
  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] bcd, input logic bit_in);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    if (adj[3:0] > 4'd4) adj[3:0] = adj[3:0] + 4'd3;
    if (adj[7:4] > 4'd4) adj[7:4] = adj[7:4] + 4'd3;
    return {adj[BCD_W-2:0], bit_in};
  endfunction

  function automatic logic [SEG_W-1:0] seg_encode(input logic [DIG_W-1:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 7-bit binary to 2-digit BCD converter, one bit per cycle, MSB first.
// The first bit is consumed on the start edge; done rises after the seventh bit.
module bin2bcd_seq
  import bcd_display_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [VAL_W-1:0] bin_i,
  output logic [BCD_W-1:0] bcd_o,
  output logic             done_o
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(VAL_W - 1);

  logic [VAL_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      bcd_q  <= dd_step('0, bin_i[VAL_W-1]);
      bin_q  <= {bin_i[VAL_W-2:0], 1'b0};
      cnt_q  <= CNT_W'(1);
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q) begin
      bcd_q <= dd_step(bcd_q, bin_q[VAL_W-1]);
      bin_q <= {bin_q[VAL_W-2:0], 1'b0};
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == LAST_STEP) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = done_q;

endmodule

// File: rtl/bcd_scan_display.sv
// Two-pair (00..99, 00..99) BCD converter with a multiplexed 4-digit 7-segment scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks a tens digit that is zero.
module bcd_scan_display
  import bcd_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [VAL_W-1:0] value_lo,
  input  logic [VAL_W-1:0] value_hi,
  input  logic             load,
  output logic             busy,
  output logic             ovf,
  output logic [3:0]       an,
  output logic [SEG_W-1:0] seg
);

  localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DISP_W = 4 * DIG_W;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  state_e            state_q;
  logic [VAL_W-1:0]  hi_q;
  logic              ovf_pend_q;
  logic [BCD_W-1:0]  lo_bcd_q;
  logic              busy_q;
  logic              ovf_q;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        an_q, an_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [DIG_W-1:0]  digit_c;

  logic              conv_start_c;
  logic [VAL_W-1:0]  conv_in_c;
  logic [BCD_W-1:0]  conv_bcd;
  logic              conv_done;

  // Single converter: low value starts on load acceptance, high value when low completes
  always_comb begin
    conv_start_c = 1'b0;
    conv_in_c    = hi_q;
    if (state_q == IDLE && load) begin
      conv_start_c = 1'b1;
      conv_in_c    = clamp99(value_lo);
    end else if (state_q == CONV_LO && conv_done) begin
      conv_start_c = 1'b1;
    end
  end

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst     (clear),
    .start_i (conv_start_c),
    .bin_i   (conv_in_c),
    .bcd_o   (conv_bcd),
    .done_o  (conv_done)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      ovf_pend_q <= 1'b0;
      lo_bcd_q   <= '0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      case (state_q)
        IDLE: if (load) begin
          hi_q       <= clamp99(value_hi);
          ovf_pend_q <= (value_lo > VAL_MAX) || (value_hi > VAL_MAX);
          busy_q     <= 1'b1;
          state_q    <= CONV_LO;
        end
        CONV_LO: if (conv_done) begin
          lo_bcd_q <= conv_bcd;
          state_q  <= CONV_HI;
        end
        CONV_HI: if (conv_done) begin
          ovf_q   <= ovf_pend_q;
          state_q <= COMMIT;
        end
        COMMIT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Scan next-state; seg is decoded from next index and next digits so an/seg move together
  always_comb begin
    disp_d = (state_q == COMMIT) ? {conv_bcd, lo_bcd_q} : disp_q;
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    idx_d  = (div_q == DIV_LAST) ? idx_q + IDX_W'(1) : idx_q;
    an_d   = ~(4'b0001 << idx_d);
    digit_c = disp_d[{idx_d, 2'b00} +: DIG_W];
    seg_d  = seg_encode(digit_c);
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_d == IDX_LO_TENS || idx_d == IDX_HI_TENS) && digit_c == '0) seg_d = SEG_BLANK;
`endif
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      disp_q <= '0;
      div_q  <= '0;
      idx_q  <= IDX_LO_ONES;
      an_q   <= 4'b1110;
      seg_q  <= SEG_0;
    end else begin
      disp_q <= disp_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign busy = busy_q;
  assign ovf  = ovf_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display: driver predicts accepted loads, monitor checks scan and commits.
module tb_bcd_scan_display;

  localparam int unsigned SD = 4;

  logic       clk = 1'b0;
  logic       clear;
  logic       load;
  logic [6:0] value_lo;
  logic [6:0] value_hi;
  logic       busy;
  logic       ovf;
  logic [3:0] an;
  logic [6:0] seg;

  bcd_scan_display #(.SCAN_DIV(SD)) dut (
    .clk      (clk),
    .clear    (clear),
    .value_lo (value_lo),
    .value_hi (value_hi),
    .load     (load),
    .busy     (busy),
    .ovf      (ovf),
    .an       (an),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              acc;
    logic [3:0][3:0] dig;
    bit              ovf;
  } exp_t;

  exp_t            sb_q[$];
  bit              clr_at[int];
  int              edge_cnt  = 0;
  int              idle_from = 0;
  int              base      = -1;
  logic [3:0][3:0] shown     = '0;
  bit              prev_busy = 1'b0;
  int              n_cmp     = 0;
  int              n_err     = 0;
  logic [6:0]      seg_tab [10];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  // Drive one cycle of inputs and predict the DUT's acceptance of load
  task automatic step(input bit clr, input bit ld, input logic [6:0] lo, input logic [6:0] hi);
    int   n;
    int   l;
    int   h;
    exp_t r;
    n        = edge_cnt + 1;
    clear    = clr;
    load     = ld;
    value_lo = lo;
    value_hi = hi;
    if (clr) begin
      clr_at[n] = 1'b1;
      idle_from = n + 1;
    end else if (ld && n >= idle_from) begin
      l        = (int'(lo) > 99) ? 99 : int'(lo);
      h        = (int'(hi) > 99) ? 99 : int'(hi);
      r.acc    = n;
      r.dig[0] = 4'(l % 10);
      r.dig[1] = 4'(l / 10);
      r.dig[2] = 4'(h % 10);
      r.dig[3] = 4'(h / 10);
      r.ovf    = (int'(lo) > 99) || (int'(hi) > 99);
      sb_q.push_back(r);
      idle_from = n + 16;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
  endtask

  // Monitor: checks scan position, digits, busy/ovf; pops the scoreboard when busy falls
  always @(negedge clk) begin
    int              e;
    logic [1:0]      ix;
    logic [3:0]      d;
    logic [3:0]      ea;
    logic [6:0]      es;
    bit              eb;
    bit              eo;
    e = edge_cnt;
    if (clr_at.exists(e)) begin
      while (sb_q.size() > 0 && sb_q[0].acc <= e) void'(sb_q.pop_front());
      shown     = '0;
      base      = e;
      prev_busy = 1'b0;
    end
    if (base >= 0) begin
      ix = 2'(((e - base) / SD) % 4);
      if (prev_busy && !busy) begin
        if (sb_q.size() == 0) begin
          check("commit_unexpected", 32'(sb_q.size()), 32'd1);
        end else begin
          check("commit_edge", 32'(e), 32'(sb_q[0].acc + 15));
          shown = sb_q[0].dig;
          void'(sb_q.pop_front());
        end
      end
      eb = (sb_q.size() > 0) && (e >= sb_q[0].acc) && (e <= sb_q[0].acc + 14);
      eo = (sb_q.size() > 0) && sb_q[0].ovf && (e == sb_q[0].acc + 14);
      check("busy", 32'(busy), 32'(eb));
      check("ovf", 32'(ovf), 32'(eo));
      ea = ~(4'b0001 << ix);
      check("an", 32'(an), 32'(ea));
      d  = shown[ix];
      es = (d < 4'd10) ? seg_tab[d] : 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
      if (ix[0] && d == 4'd0) es = 7'b1111111;
`endif
      check("seg", 32'(seg), 32'(es));
      prev_busy = busy;
    end
  end

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    step(1'b1, 1'b0, 7'd0, 7'd0);
    repeat (20) idle();
    // Basic conversion, then overflow clamp
    step(1'b0, 1'b1, 7'd59, 7'd7);
    repeat (20) idle();
    step(1'b0, 1'b1, 7'd120, 7'd99);
    repeat (20) idle();
    // Second load during conversion is dropped
    step(1'b0, 1'b1, 7'd23, 7'd45);
    repeat (4) idle();
    step(1'b0, 1'b1, 7'd88, 7'd66);
    repeat (20) idle();
    // Clear mid-conversion aborts
    step(1'b0, 1'b1, 7'd77, 7'd110);
    repeat (7) idle();
    step(1'b1, 1'b0, 7'd0, 7'd0);
    repeat (20) idle();
    // Leading-zero tens on the high pair
    step(1'b0, 1'b1, 7'd42, 7'd3);
    repeat (20) idle();
    // Clear wins over a simultaneous load
    step(1'b1, 1'b1, 7'd50, 7'd50);
    repeat (20) idle();
    // Loads at the COMMIT edge (ignored) and the first IDLE edge (accepted)
    step(1'b0, 1'b1, 7'd10, 7'd20);
    repeat (14) idle();
    step(1'b0, 1'b1, 7'd31, 7'd64);
    step(1'b0, 1'b1, 7'd8, 7'd90);
    repeat (20) idle();

    for (int t = 0; t < 400; t++) begin
      int r;
      r = int'($urandom_range(0, 29));
      if (r == 0) step(1'b1, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
      else if (r < 6) step(1'b0, 1'b1, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
      else idle();
    end
    repeat (24) idle();

    #1;
    check("queue_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles each digit is displayed per scan step (legal range 2..2^20).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port clear  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port value_lo  input  7  binary count 0..99 from the low counter stage.
REQ-005 SHALL have port value_hi  input  7  binary count 0..99 from the high counter stage.
REQ-006 SHALL have port load  input  1  single-cycle request to sample value_lo/value_hi.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port ovf  output  1  one-cycle pulse at commit if either sampled value exceeded 99.
REQ-009 SHALL have port an  output  4  digit enables, active-low, one-hot.
REQ-010 SHALL have port seg  output  7  segments, active-low, seg[6]=g..seg[0]=a.

Function
REQ-011 SHALL use FSM states IDLE, CONV_LO, CONV_HI, COMMIT.
REQ-012 SHALL accept load only in IDLE; load while busy is ignored, not queued.
REQ-013 SHALL, on accepting load at edge N, capture both inputs, enter CONV_LO and assert busy from N+1.
REQ-014 SHALL convert each value by shift-add-3 (double dabble), one bit per cycle, 7 cycles per value, MSB first.
REQ-015 SHALL spend exactly 7 cycles in CONV_LO, 7 in CONV_HI and 1 in COMMIT; display digit registers update and busy falls at edge N+15.
REQ-016 SHALL clamp any captured value above 99 to 99 before conversion and pulse ovf in the COMMIT cycle.
REQ-017 SHALL hold the previous displayed digits unchanged until COMMIT.
REQ-018 SHALL run a scan divider 0..SCAN_DIV-1 continuously; on terminal count, wrap to 0 and advance digit index 0->1->2->3->0.
REQ-019 SHALL map digit index 0=lo ones, 1=lo tens, 2=hi ones, 3=hi tens; an = ~(4'b0001 << index).
REQ-020 SHALL drive seg from the registered digit for the current index, registered (one-cycle delay relative to an change is not permitted: an and seg update on the same edge).
REQ-021 SHALL encode digits 0..9 active-low; 0=1000000, 1=1111001, 5=0010010, 9=0010000; codes 10..15 shall output blank 1111111.
REQ-022 SHALL continue scanning unaffected by conversion activity.

Reset
REQ-023 SHALL, with clear high at an edge, force FSM to IDLE, busy=0, ovf=0, all digit registers 0, scan divider 0, index 0.
REQ-024 SHALL, after clear, present an=1110 and seg=1000000 on the next cycle.
REQ-025 SHALL abort any conversion in progress on clear; partial results are discarded; clear dominates a simultaneous load.

Configuration
REQ-026 SHALL recognise macro LEADING_ZERO_BLANK_EN.
REQ-027 SHALL, with LEADING_ZERO_BLANK_EN defined, blank (seg=1111111) a tens digit whose value is 0 (per pair: index 1 and index 3 independently).
REQ-028 SHALL, without LEADING_ZERO_BLANK_EN, display every digit including leading zeros.

Structure
REQ-029 SHALL place FSM state typedef, segment code constants (digits 0..9, BLANK) and digit-index constants in shared package bcd_display_pkg.
REQ-030 SHALL implement one sequential converter sub-module bin2bcd_seq (start, 7-bit in, 8-bit BCD out, done), instantiated once and reused for lo then hi.
REQ-031 SHALL keep the scan divider and segment decode in the top module.

Verification
REQ-032 SHALL cover: clear, no load -> an=1110, seg=1000000; all digits 0 across a full scan.
REQ-033 SHALL cover: value_lo=59, value_hi=7, load at edge N -> busy N+1..N+15, digits {9,5,7,0} at N+15; index 1 seg=0010010.
REQ-034 SHALL cover: value_lo=120, value_hi=99, load -> ovf one cycle at COMMIT, both pairs display 99.
REQ-035 SHALL cover: second load at N+5 with different values -> ignored; result reflects first sample only.
REQ-036 SHALL cover: clear at N+8 mid-conversion -> busy 0 next cycle, digits 0, no ovf.
REQ-037 SHALL cover: SCAN_DIV=4, value_hi=3 with LEADING_ZERO_BLANK_EN -> an sequence 1110,1101,1011,0111 every 4 cycles; index 3 seg=1111111; without macro index 3 seg=1000000.
